error_metric_accumulator: RTL
=============================

ERROR_METRIC_ACCUMULATOR -- requirements
Module: error_metric_accumulator

Interface
REQ-001 Parameter: width, 24, operand width of the adder under characterisation; sample inputs are width+1 bits.
REQ-002 Parameter: count_width, 16, width of the sample-count request and counters.
REQ-003 Parameter: acc_width, width+1+count_width, width of the error-distance sum.
REQ-004 Port: clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst_i  input  1  synchronous, active-high reset.
REQ-006 Port: start_i  input  1  one-cycle request to begin a characterisation run.
REQ-007 Port: num_samples_i  input  count_width  samples in the run; sampled only when start_i is accepted.
REQ-008 Port: valid_i  input  1  approx_i/exact_i hold a sample.
REQ-009 Port: ready_o  output  1  block accepts a sample this cycle.
REQ-010 Port: approx_i  input  width+1  result of the approximate adder (carry-out in MSB).
REQ-011 Port: exact_i  input  width+1  result of the exact ripple-carry adder for the same operands.
REQ-012 Port: busy_o  output  1  run in progress.
REQ-013 Port: done_o  output  1  results valid and held.
REQ-014 Port: err_count_o  output  count_width  samples with non-zero error distance.
REQ-015 Port: sum_ed_o  output  acc_width  sum of absolute error distances.
REQ-016 Port: max_ed_o  output  width+1  largest absolute error distance seen.

Function
REQ-017 States SHALL be IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE: start_i with num_samples_i != 0 -> RUN, clearing counters/accumulators; start_i with num_samples_i == 0 -> DONE with all results zero.
REQ-019 ready_o SHALL be 1 only in RUN; a sample is accepted when valid_i && ready_o.
REQ-020 Each accepted sample SHALL compute ED = |approx_i - exact_i| (unsigned, width+1 bits, no wrap) and register it (stage 1); stage 2 updates sum, max and error count one cycle later.
REQ-021 Accept counter SHALL increment per accepted sample; on the cycle the num_samples-th sample is accepted, state -> FLUSH and ready_o drops next cycle.
REQ-022 FLUSH SHALL last exactly one cycle (last stage-2 update) then -> DONE.
REQ-023 sum_ed_o SHALL saturate at all-ones; err_count_o and max_ed_o never wrap by construction.
REQ-024 DONE: done_o = 1, results held stable; start_i restarts per REQ-018 (done_o drops next cycle).
REQ-025 busy_o SHALL be 1 in RUN and FLUSH only.
REQ-026 start_i in RUN or FLUSH SHALL be ignored; valid_i outside RUN SHALL be ignored.
REQ-027 valid_i gaps in RUN SHALL stall the run without altering results.

Reset
REQ-028 rst_i SHALL force IDLE and zero every output (ready_o, busy_o, done_o, err_count_o, sum_ed_o, max_ed_o) and all internal counters/pipeline registers on the next edge.
REQ-029 rst_i asserted mid-run SHALL discard the partial run; no done_o is produced.

Structure
REQ-030 Shared package approx_metrics_pkg SHALL hold the state encoding and default width/count_width constants.
REQ-031 Absolute difference SHALL be a sub-module abs_difference (parameter width+1, combinational).

Verification (width=24)
REQ-032 start, num=4, samples (approx,exact) = (10,10),(12,10),(5,9),(0,0) -> done_o, sum_ed_o=6, max_ed_o=4, err_count_o=2.
REQ-033 start, num=0 -> DONE in one cycle, all results 0, ready_o never 1.
REQ-034 num=3 with valid_i toggling 1,0,0,1,0,1; (7,0) each -> sum 21, max 7, count 3; ready_o low the cycle after third accept.
REQ-035 Reduce acc_width to 25, num=3, each ED=2^24 -> sum_ed_o saturates at 2^25-1.
REQ-036 rst_i after 2 of 5 samples -> outputs zero next cycle, IDLE; new run num=1,(3,1) -> sum 2, count 1.
REQ-037 start_i pulsed during RUN -> ignored, counts unchanged; approx_i carry-out set (2^24 vs 0) -> max_ed_o=2^24.

Source files
------------

// File: rtl/approx_metrics_pkg.sv
// Shared definitions for approximate-adder error metrics.
// Holds the FSM encoding and default operand/counter widths.
package approx_metrics_pkg;

    localparam int WIDTH_DEFAULT       = 24;
    localparam int COUNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_difference.sv
// Unsigned absolute difference of two equal-width operands.
// Result never wraps: the larger operand is always the minuend.
module abs_difference #(
    parameter int width = 25
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] diff
);

    // Subtract the smaller value from the larger one.
    always_comb begin
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
    end

endmodule

// File: rtl/error_metric_accumulator.sv
// Accumulates error-distance metrics of an approximate adder
// against an exact adder over a requested number of samples.
module error_metric_accumulator
    import approx_metrics_pkg::*;
#(
    parameter int width       = WIDTH_DEFAULT,
    parameter int count_width = COUNT_WIDTH_DEFAULT,
    parameter int acc_width   = width + 1 + count_width
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [count_width-1:0] num_samples_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width:0]         approx_i,
    input  logic [width:0]         exact_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [count_width-1:0] err_count_o,
    output logic [acc_width-1:0]   sum_ed_o,
    output logic [width:0]         max_ed_o
);

    state_t                 state;
    state_t                 state_next;
    logic                   start_run;
    logic                   start_empty;
    logic                   accept;
    logic                   last_accept;
    logic [count_width-1:0] target;
    logic [count_width-1:0] accepted;
    logic [width:0]         ed;
    logic                   s1_valid;
    logic [width:0]         s1_ed;
    logic [count_width-1:0] err_count;
    logic [acc_width-1:0]   sum_ed;
    logic [width:0]         max_ed;
    logic [acc_width:0]     sum_wide;
    logic [acc_width-1:0]   sum_sat;

    abs_difference #(
        .width(width + 1)
    ) u_abs (
        .a    (approx_i),
        .b    (exact_i),
        .diff (ed)
    );

    assign accept      = valid_i && (state == ST_RUN);
    assign last_accept = (accepted + count_width'(1)) == target;

    // Next-state decode and status outputs.
    always_comb begin
        state_next  = state;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        start_run   = 1'b0;
        start_empty = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                done_o = (state == ST_DONE);
                if (start_i) begin
                    if (num_samples_i != '0) begin
                        start_run  = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        start_empty = 1'b1;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (accept && last_accept) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy_o     = 1'b1;
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stage 1: register the error distance of each accepted sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target   <= '0;
            accepted <= '0;
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else if (start_run || start_empty) begin
            target   <= num_samples_i;
            accepted <= '0;
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ed    <= ed;
                accepted <= accepted + count_width'(1);
            end
        end
    end

    assign sum_wide = {1'b0, sum_ed} + (acc_width + 1)'(s1_ed);
    assign sum_sat  = sum_wide[acc_width] ? '1 : sum_wide[acc_width-1:0];

    // Stage 2: fold the registered distance into sum, max and count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (start_run || start_empty) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (s1_valid) begin
            sum_ed <= sum_sat;
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
            end
            if (s1_ed != '0) begin
                err_count <= err_count + count_width'(1);
            end
        end
    end

    assign err_count_o = err_count;
    assign sum_ed_o    = sum_ed;
    assign max_ed_o    = max_ed;

endmodule
